// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one sprite ROM between several reel renderers.
// Grants a burst, issues one ROM address per cycle and tags returned words with the owner id.
module sprite_rom_arbiter #(
   parameter int unsigned NUM_REQ = 3,
   parameter int unsigned ROM_LAT = 2,
   parameter int unsigned LEN_W   = 5
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_REQ-1:0]           req_i,
   input  logic [3*NUM_REQ-1:0]         sprite_i,
   input  logic [10*NUM_REQ-1:0]        addr_i,
   input  logic [LEN_W*NUM_REQ-1:0]     len_i,
   output logic [NUM_REQ-1:0]           ack_o,
   output logic                         busy_o,
   output logic [2:0]                   rom_sprite_sel_o,
   output logic [9:0]                   rom_word_addr_o,
   input  logic [15:0]                  rom_data_i,
   output logic                         rd_valid_o,
   output logic [$clog2(NUM_REQ)-1:0]   rd_id_o,
   output logic                         rd_last_o,
   output logic [15:0]                  rd_data_o
);

   localparam int unsigned ID_W   = $clog2(NUM_REQ);
   localparam int unsigned SPR_W  = 3;
   localparam int unsigned ADDR_W = 10;

   typedef enum logic {
      IDLE  = 1'b0,
      ISSUE = 1'b1
   } state_t;

   typedef struct packed {
      logic            valid;
      logic [ID_W-1:0] id;
      logic            last;
   } ret_t;

   state_t state_q, state_d;

   logic [ID_W-1:0]   last_grant_q;
   logic [ID_W-1:0]   id_q;
   logic [LEN_W-1:0]  beat_q;
   logic [LEN_W-1:0]  len_q;
   logic              beat_last_c;

   logic              grant_valid_c;
   logic [ID_W-1:0]   grant_id_c;
   logic [ID_W-1:0]   cand_c;

   logic [NUM_REQ-1:0]  ack_d;
   logic                busy_d;
   logic [SPR_W-1:0]    spr_d;
   logic [ADDR_W-1:0]   addr_d;
   ret_t                push_d;

   ret_t ret_q [ROM_LAT];

   logic [SPR_W-1:0]  spr_arr  [NUM_REQ];
   logic [ADDR_W-1:0] addr_arr [NUM_REQ];
   logic [LEN_W-1:0]  len_arr  [NUM_REQ];

   // Unpack the flat per-requester buses
   for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
      assign spr_arr[k]  = sprite_i[SPR_W*k +: SPR_W];
      assign addr_arr[k] = addr_i[ADDR_W*k +: ADDR_W];
      assign len_arr[k]  = len_i[LEN_W*k +: LEN_W];
   end

   assign beat_last_c = (beat_q == len_q);

   // Rotating search from last_grant+1; descending loop leaves the nearest candidate
   always_comb begin
      grant_valid_c = 1'b0;
      grant_id_c    = '0;
      cand_c        = '0;
      for (int i = int'(NUM_REQ); i >= 1; i--) begin
         cand_c = ID_W'((int'(last_grant_q) + i) % int'(NUM_REQ));
         if (req_i[cand_c]) begin
            grant_valid_c = 1'b1;
            grant_id_c    = cand_c;
         end
      end
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (grant_valid_c) begin
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (beat_last_c) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Next values for the registered outputs and the return-tag push
   always_comb begin
      ack_d  = '0;
      busy_d = (state_d == ISSUE);
      spr_d  = rom_sprite_sel_o;
      addr_d = rom_word_addr_o;
      push_d = '0;
      case (state_q)
         IDLE: begin
            if (grant_valid_c) begin
               ack_d[grant_id_c] = 1'b1;
               spr_d             = spr_arr[grant_id_c];
               addr_d            = addr_arr[grant_id_c];
            end
         end
         ISSUE: begin
            push_d.valid = 1'b1;
            push_d.id    = id_q;
            push_d.last  = beat_last_c;
            if (!beat_last_c) begin
               addr_d = rom_word_addr_o + 10'd1;
            end
         end
         default: ;
      endcase
   end

   // Burst bookkeeping and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_grant_q     <= ID_W'(NUM_REQ - 1);
         id_q             <= '0;
         beat_q           <= '0;
         len_q            <= '0;
         ack_o            <= '0;
         busy_o           <= 1'b0;
         rom_sprite_sel_o <= '0;
         rom_word_addr_o  <= '0;
      end else begin
         ack_o            <= ack_d;
         busy_o           <= busy_d;
         rom_sprite_sel_o <= spr_d;
         rom_word_addr_o  <= addr_d;
         if (state_q == IDLE) begin
            if (grant_valid_c) begin
               last_grant_q <= grant_id_c;
               id_q         <= grant_id_c;
               len_q        <= len_arr[grant_id_c];
               beat_q       <= '0;
            end
         end else begin
            beat_q <= beat_last_c ? '0 : beat_q + LEN_W'(1);
         end
      end
   end

   // Return tags track the ROM pipeline; tail stage lines up with rom_data_i
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < int'(ROM_LAT); k++) begin
            ret_q[k] <= '0;
         end
      end else begin
         ret_q[0] <= push_d;
         for (int k = 1; k < int'(ROM_LAT); k++) begin
            ret_q[k] <= ret_q[k-1];
         end
      end
   end

   assign rd_valid_o = ret_q[ROM_LAT-1].valid;
   assign rd_id_o    = ret_q[ROM_LAT-1].id;
   assign rd_last_o  = ret_q[ROM_LAT-1].last;
   assign rd_data_o  = rom_data_i;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter: vector table of single bursts plus
// hand-written sequences for round robin, overlap, late arrival and mid-burst reset.
module tb_sprite_rom_arbiter;

   localparam int NUM_REQ = 3;
   localparam int LAT     = 2;
   localparam int LEN_W   = 5;

   logic                   clk;
   logic                   reset;
   logic [NUM_REQ-1:0]     req_i;
   logic [3*NUM_REQ-1:0]   sprite_i;
   logic [10*NUM_REQ-1:0]  addr_i;
   logic [LEN_W*NUM_REQ-1:0] len_i;
   logic [NUM_REQ-1:0]     ack_o;
   logic                   busy_o;
   logic [2:0]             rom_sprite_sel_o;
   logic [9:0]             rom_word_addr_o;
   logic [15:0]            rom_data_i;
   logic                   rd_valid_o;
   logic [1:0]             rd_id_o;
   logic                   rd_last_o;
   logic [15:0]            rd_data_o;

   int total = 0;
   int bad   = 0;

   sprite_rom_arbiter #(.NUM_REQ(NUM_REQ), .ROM_LAT(LAT), .LEN_W(LEN_W)) dut (
      .clk(clk), .reset(reset), .req_i(req_i), .sprite_i(sprite_i), .addr_i(addr_i),
      .len_i(len_i), .ack_o(ack_o), .busy_o(busy_o), .rom_sprite_sel_o(rom_sprite_sel_o),
      .rom_word_addr_o(rom_word_addr_o), .rom_data_i(rom_data_i), .rd_valid_o(rd_valid_o),
      .rd_id_o(rd_id_o), .rd_last_o(rd_last_o), .rd_data_o(rd_data_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] rom_word(input logic [2:0] s, input logic [9:0] a);
      return (s == 3'd7) ? 16'h0000 : {s, 3'b101, a};
   endfunction

   // Two-cycle ROM model
   logic [15:0] rom_p1;
   always @(posedge clk) begin
      rom_p1     <= rom_word(rom_sprite_sel_o, rom_word_addr_o);
      rom_data_i <= rom_p1;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic set_req(input int id, input logic [2:0] s, input logic [9:0] a, input int l);
      req_i[id]             = 1'b1;
      sprite_i[3*id +: 3]   = s;
      addr_i[10*id +: 10]   = a;
      len_i[LEN_W*id +: LEN_W] = LEN_W'(l);
   endtask

   // Burst A, optionally followed by burst B requested during A's ack cycle
   task automatic run_pair(input string nm,
                           input int ia, input logic [2:0] sa, input logic [9:0] aa, input int la,
                           input logic [2:0] acka, input logic [9:0] last_a,
                           input bit use_b,
                           input int ib, input logic [2:0] sb, input logic [9:0] ab, input int lb,
                           input logic [2:0] ackb);
      int n_a, n_b, tb_, cycles, ra, rb;
      logic [2:0] e_ack;
      logic e_busy, e_v, e_last;
      logic [1:0] e_id;
      logic [15:0] e_data;
      n_a = la + 1;
      n_b = lb + 1;
      tb_ = n_a + 2;
      cycles = use_b ? tb_ + n_b + LAT + 1 : n_a + LAT + 2;
      @(negedge clk);
      set_req(ia, sa, aa, la);
      for (int t = 1; t <= cycles; t++) begin
         @(negedge clk);
         e_ack = '0;
         if (t == 1) e_ack = acka;
         if (use_b && t == tb_) e_ack = ackb;
         e_busy = (t <= n_a) || (use_b && t >= tb_ && t < tb_ + n_b);
         chk($sformatf("%s t%0d ack", nm, t), 32'(ack_o), 32'(e_ack));
         chk($sformatf("%s t%0d busy", nm, t), 32'(busy_o), 32'(e_busy));
         if (t <= n_a) begin
            chk($sformatf("%s t%0d spr", nm, t), 32'(rom_sprite_sel_o), 32'(sa));
            chk($sformatf("%s t%0d addr", nm, t), 32'(rom_word_addr_o), 32'(10'(aa + 10'(t - 1))));
            if (t == n_a)
               chk($sformatf("%s last addr", nm), 32'(rom_word_addr_o), 32'(last_a));
         end
         if (use_b && t >= tb_ && t < tb_ + n_b) begin
            chk($sformatf("%s t%0d spr b", nm, t), 32'(rom_sprite_sel_o), 32'(sb));
            chk($sformatf("%s t%0d addr b", nm, t), 32'(rom_word_addr_o), 32'(10'(ab + 10'(t - tb_))));
         end
         ra = t - 1 - LAT;
         rb = t - tb_ - LAT;
         e_v = 1'b0; e_id = '0; e_last = 1'b0; e_data = '0;
         if (ra >= 0 && ra < n_a) begin
            e_v = 1'b1; e_id = 2'(ia); e_last = (ra == n_a - 1);
            e_data = rom_word(sa, 10'(aa + 10'(ra)));
         end else if (use_b && rb >= 0 && rb < n_b) begin
            e_v = 1'b1; e_id = 2'(ib); e_last = (rb == n_b - 1);
            e_data = rom_word(sb, 10'(ab + 10'(rb)));
         end
         chk($sformatf("%s t%0d rd_valid", nm, t), 32'(rd_valid_o), 32'(e_v));
         if (e_v) begin
            chk($sformatf("%s t%0d rd_id", nm, t), 32'(rd_id_o), 32'(e_id));
            chk($sformatf("%s t%0d rd_last", nm, t), 32'(rd_last_o), 32'(e_last));
            chk($sformatf("%s t%0d rd_data", nm, t), 32'(rd_data_o), 32'(e_data));
         end
         if (t == 1) begin
            req_i[ia] = 1'b0;
            if (use_b) set_req(ib, sb, ab, lb);
         end
         if (use_b && t == tb_) req_i[ib] = 1'b0;
      end
      repeat (3) @(negedge clk);
   endtask

   typedef struct {
      int         id;
      logic [2:0] spr;
      logic [9:0] addr;
      int         len;
      logic [2:0] exp_ack;
      logic [9:0] exp_last;
   } vec_t;

   vec_t vecs [5];
   logic [2:0] exp_rr [6];
   int  gcyc [6];
   logic [2:0] gack [6];
   int  n;

   initial begin
      vecs[0] = '{0, 3'd2, 10'h010, 3,  3'b001, 10'h013};
      vecs[1] = '{1, 3'd5, 10'd1022, 3, 3'b010, 10'd1};
      vecs[2] = '{2, 3'd7, 10'h155, 0,  3'b100, 10'h155};
      vecs[3] = '{0, 3'd1, 10'h3FF, 31, 3'b001, 10'h01E};
      vecs[4] = '{1, 3'd0, 10'h000, 1,  3'b010, 10'h001};
      exp_rr  = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

      reset = 1'b1; req_i = '0; sprite_i = '0; addr_i = '0; len_i = '0;
      repeat (3) @(negedge clk);
      chk("reset ack", 32'(ack_o), 0);
      chk("reset busy", 32'(busy_o), 0);
      chk("reset spr", 32'(rom_sprite_sel_o), 0);
      chk("reset addr", 32'(rom_word_addr_o), 0);
      chk("reset rd_valid", 32'(rd_valid_o), 0);
      chk("reset rd_id", 32'(rd_id_o), 0);
      chk("reset rd_last", 32'(rd_last_o), 0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // Round robin: all requesters held, single-word bursts
      for (int k = 0; k < NUM_REQ; k++) begin
         sprite_i[3*k +: 3] = 3'(k); addr_i[10*k +: 10] = 10'(k * 16);
      end
      req_i = 3'b111;
      n = 0;
      for (int c = 1; c <= 30 && n < 6; c++) begin
         @(negedge clk);
         if (ack_o != '0) begin
            gack[n] = ack_o; gcyc[n] = c; n++;
            if (n == 6) req_i = '0;
         end
      end
      chk("rr grant count", 32'(n), 6);
      if (n > 0) chk("rr first grant cycle", 32'(gcyc[0]), 1);
      for (int k = 0; k < n; k++) begin
         chk($sformatf("rr grant %0d", k), 32'(gack[k]), 32'(exp_rr[k]));
         if (k > 0) chk($sformatf("rr spacing %0d", k), 32'(gcyc[k] - gcyc[k-1]), 2);
      end
      req_i = '0;
      repeat (4) @(negedge clk);

      for (int v = 0; v < 5; v++) begin
         run_pair($sformatf("vec%0d", v), vecs[v].id, vecs[v].spr, vecs[v].addr, vecs[v].len,
                  vecs[v].exp_ack, vecs[v].exp_last, 1'b0, 0, 3'd0, 10'd0, 0, 3'b000);
      end

      run_pair("overlap", 0, 3'd4, 10'h020, 1, 3'b001, 10'h021,
               1'b1, 2, 3'd6, 10'h2A0, 0, 3'b100);
      run_pair("late_req", 0, 3'd3, 10'h200, 2, 3'b001, 10'h202,
               1'b1, 1, 3'd1, 10'h3FE, 4, 3'b010);

      // Reset during beat 2 of an 8-word burst
      @(negedge clk);
      set_req(0, 3'd3, 10'h100, 7);
      @(negedge clk);
      chk("rst_mid ack", 32'(ack_o), 32'(3'b001));
      req_i = '0;
      repeat (2) @(negedge clk);
      chk("rst_mid beat2 addr", 32'(rom_word_addr_o), 32'(10'h102));
      chk("rst_mid pre valid", 32'(rd_valid_o), 1);
      #2 reset = 1'b1;
      #1;
      chk("rst_mid ack0", 32'(ack_o), 0);
      chk("rst_mid busy0", 32'(busy_o), 0);
      chk("rst_mid spr0", 32'(rom_sprite_sel_o), 0);
      chk("rst_mid addr0", 32'(rom_word_addr_o), 0);
      chk("rst_mid valid0", 32'(rd_valid_o), 0);
      chk("rst_mid id0", 32'(rd_id_o), 0);
      chk("rst_mid last0", 32'(rd_last_o), 0);
      @(negedge clk);
      reset = 1'b0;
      for (int t = 0; t < 8; t++) begin
         @(negedge clk);
         chk($sformatf("rst_mid post t%0d valid", t), 32'(rd_valid_o), 0);
         chk($sformatf("rst_mid post t%0d busy", t), 32'(busy_o), 0);
      end
      len_i = '0;
      req_i = 3'b111;
      @(negedge clk);
      chk("rst_mid first grant", 32'(ack_o), 32'(3'b001));
      req_i = '0;
      repeat (4) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
